// File: rtl/demux_pkg.sv
// Shared definitions for the round-robin / explicit 1-to-N stream demultiplexer.
// Holds the mode encodings and the pointer wrap helper.
package demux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Next round-robin position, wrapping from n-1 back to 0.
  function automatic int ptr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single output channel.
// A load always wins over a drain, so a same-cycle drain+reload keeps the channel full.
module demux_chan_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_rr_1xn.sv
// Registered 1-to-N stream demultiplexer; the target is SEL (explicit) or an internal
// round-robin pointer. Each channel stalls independently through its own holding register.
module demux_rr_1xn
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 2,
  parameter int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [SW-1:0]    ptr,
  output logic             sel_err
);

  logic [SW-1:0] ptr_reg;
  logic          sel_err_reg;
  logic [SW-1:0] tgt;
  logic          tgt_ok;
  logic          tgt_free;
  logic          accept;
  logic [N-1:0]  load;

  // The pointer is always in range; only an explicit SEL can name a missing channel.
  always_comb begin
    tgt      = (mode == MODE_RR) ? ptr_reg : sel;
    tgt_ok   = (mode == MODE_RR) || (32'(sel) < N);
    tgt_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (tgt == SW'(k)) tgt_free = ~out_valid[k] | out_ready[k];
    end
  end

  assign in_ready = tgt_ok & tgt_free;
  assign accept   = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign load[gi] = accept && (tgt == SW'(gi));

      demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[gi]),
        .din   (in_data),
        .ready (out_ready[gi]),
        .valid (out_valid[gi]),
        .dout  (out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (accept && (mode == MODE_RR)) begin
      ptr_reg <= SW'(ptr_next(32'(ptr_reg), N));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else if ((mode == MODE_SEL) && in_valid && !tgt_ok) begin
      sel_err_reg <= 1'b1;
    end
  end

  assign ptr     = ptr_reg;
  assign sel_err = sel_err_reg;

endmodule
